// File: rtl/branch_unit.sv
// Branch unit: holds the architectural CIA, LR, CTR and optional TAR. It decodes Power ISA
// I/B/XL-form branches and computes the next-instruction address (NIA). The NIA goes to fetch
// through a single registered valid/ready stage.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_32b_mode            32-bit mode: NIA upper bits cleared, CTR test on CTR[31:0]
//   i_valid / o_ready     instruction handshake from decode
//   i_instr, i_cr         instruction word and condition register
//   o_valid / i_ready     result handshake to fetch
//   o_next_instr_addr     NIA; o_taken / o_illegal qualify it
//   i_spr_we/sel/wdata    SPR write port (0 = LR, 1 = CTR, 2 = TAR)
//   o_lr, o_ctr, o_tar    architectural register values
//   i_redirect(_addr)     exception/interrupt redirect, highest priority
module branch_unit #(
  parameter int unsigned ADDR_W     = 64,
  parameter logic [63:0] RESET_ADDR = 64'h100,
  parameter bit          HAS_TAR    = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_32b_mode,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [31:0]       i_cr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_next_instr_addr,
  output logic              o_taken,
  output logic              o_illegal,
  input  logic              i_spr_we,
  input  logic [1:0]        i_spr_sel,
  input  logic [ADDR_W-1:0] i_spr_wdata,
  output logic [ADDR_W-1:0] o_lr,
  output logic [ADDR_W-1:0] o_ctr,
  output logic [ADDR_W-1:0] o_tar,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr
);

  localparam logic [ADDR_W-1:0] ResetAddr = RESET_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] Low32     = ADDR_W'(64'hFFFF_FFFF);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    KindNone,
    KindB,
    KindBc,
    KindBclr,
    KindBcctr,
    KindBctar,
    KindIllegal
  } kind_e;

  logic [ADDR_W-1:0] cia_q, lr_q, ctr_q, tar_q, nia_q;
  logic              valid_q, taken_q, illegal_q;

  // Instruction fields (ISA bit n is i_instr[31-n]).
  logic [5:0] opcode;
  logic [4:0] bo;   // bo[4] is ISA BO[0], bo[1] is ISA BO[3]
  logic [4:0] bi;
  logic [9:0] xo;
  logic       aa, lk;

  assign opcode = i_instr[31:26];
  assign bo     = i_instr[25:21];
  assign bi     = i_instr[20:16];
  assign xo     = i_instr[10:1];
  assign aa     = i_instr[1];
  assign lk     = i_instr[0];

  kind_e             kind;
  logic              accept, uses_cond, dec_ctr, ctr_nz, ctr_ok, cond_ok, taken_c, link;
  logic [ADDR_W-1:0] exts_li, exts_bd, base, seq_addr, target, nia_c, ctr_m;

  function automatic logic [ADDR_W-1:0] mode_mask(input logic mode, input logic [ADDR_W-1:0] a);
    return mode ? (a & Low32) : a;
  endfunction

  // A redirect steals the cycle, so decode is told we cannot accept.
  assign o_ready = (!valid_q || i_ready) && !i_redirect;
  assign accept  = i_valid && o_ready;

  always_comb begin
    kind = KindNone;
    case (opcode)
      6'd18: kind = KindB;
      6'd16: kind = KindBc;
      6'd19: begin
        case (xo)
          10'd16:  kind = KindBclr;
          10'd528: kind = bo[2] ? KindBcctr : KindIllegal;
          10'd560: kind = HAS_TAR ? KindBctar : KindIllegal;
          default: kind = KindIllegal;
        endcase
      end
      default: kind = KindNone;
    endcase
  end

  assign exts_li  = {{(ADDR_W-26){i_instr[25]}}, i_instr[25:2], 2'b00};
  assign exts_bd  = {{(ADDR_W-16){i_instr[15]}}, i_instr[15:2], 2'b00};
  assign base     = aa ? '0 : cia_q;
  assign seq_addr = cia_q + ADDR_W'(4);

  assign uses_cond = (kind == KindBc) || (kind == KindBclr) || (kind == KindBcctr) ||
                     (kind == KindBctar);
  // bcctr with BO[2] = 0 never reaches here: it decodes as illegal.
  assign dec_ctr   = uses_cond && !bo[2];
  assign ctr_m     = ctr_q - ADDR_W'(1);
  assign ctr_nz    = i_32b_mode ? (ctr_m[31:0] != 32'd0) : (ctr_m != '0);
  assign ctr_ok    = bo[2] || (ctr_nz ^ bo[1]);
  assign cond_ok   = bo[4] || (i_cr[5'd31 - bi] == bo[3]);
  assign taken_c   = (kind == KindB) || (uses_cond && ctr_ok && cond_ok);
  assign link      = lk && (kind != KindNone) && (kind != KindIllegal);

  always_comb begin
    target = seq_addr;
    case (kind)
      KindB:     target = exts_li + base;
      KindBc:    target = exts_bd + base;
      KindBclr:  target = lr_q & AlignMask;
      KindBcctr: target = ctr_q & AlignMask;
      KindBctar: target = tar_q & AlignMask;
      default:   target = seq_addr;
    endcase
  end

  assign nia_c = mode_mask(i_32b_mode, taken_c ? target : seq_addr);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cia_q     <= ResetAddr;
      nia_q     <= ResetAddr;
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      lr_q      <= '0;
      ctr_q     <= '0;
      tar_q     <= '0;
    end else begin
      if (i_redirect) begin
        cia_q     <= i_redirect_addr;
        nia_q     <= i_redirect_addr;
        valid_q   <= 1'b1;
        taken_q   <= 1'b1;
        illegal_q <= 1'b0;
      end else if (accept) begin
        cia_q     <= nia_c;
        nia_q     <= nia_c;
        valid_q   <= 1'b1;
        taken_q   <= taken_c;
        illegal_q <= (kind == KindIllegal);
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end

      // Branch updates override a coincident SPR write to the same register.
      if (accept && link) begin
        lr_q <= mode_mask(i_32b_mode, seq_addr);
      end else if (i_spr_we && i_spr_sel == 2'd0) begin
        lr_q <= i_spr_wdata;
      end

      if (accept && dec_ctr) begin
        ctr_q <= ctr_m;
      end else if (i_spr_we && i_spr_sel == 2'd1) begin
        ctr_q <= i_spr_wdata;
      end

      if (HAS_TAR && i_spr_we && i_spr_sel == 2'd2) begin
        tar_q <= i_spr_wdata;
      end
    end
  end

  assign o_valid           = valid_q;
  assign o_next_instr_addr = nia_q;
  assign o_taken           = taken_q;
  assign o_illegal         = illegal_q;
  assign o_lr              = lr_q;
  assign o_ctr             = ctr_q;
  assign o_tar             = tar_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] cr = '0;
  logic        spr_we = 1'b0;
  logic [1:0]  spr_sel = '0;
  logic [63:0] spr_wdata = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_addr = '0;

  logic        o_ready, o_valid, o_taken, o_illegal;
  logic [63:0] o_nia, o_lr, o_ctr, o_tar;

  int checks = 0;
  int failures = 0;

  // Reference state.
  logic [63:0] m_cia, m_lr, m_ctr, e_nia;
  logic        e_valid, e_taken, e_ill, e_ready;

  always #5 clk = ~clk;

  branch_unit #(
    .ADDR_W    (64),
    .RESET_ADDR(64'h100),
    .HAS_TAR   (1'b0)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_32b_mode       (mode),
    .i_valid          (in_valid),
    .o_ready          (o_ready),
    .i_instr          (instr),
    .i_cr             (cr),
    .o_valid          (o_valid),
    .i_ready          (out_ready),
    .o_next_instr_addr(o_nia),
    .o_taken          (o_taken),
    .o_illegal        (o_illegal),
    .i_spr_we         (spr_we),
    .i_spr_sel        (spr_sel),
    .i_spr_wdata      (spr_wdata),
    .o_lr             (o_lr),
    .o_ctr            (o_ctr),
    .o_tar            (o_tar),
    .i_redirect       (redirect),
    .i_redirect_addr  (redirect_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] msk(input logic m, input logic [63:0] a);
    return m ? (a & 64'hFFFF_FFFF) : a;
  endfunction

  task automatic model_reset();
    m_cia = 64'h100; e_nia = 64'h100; m_lr = 0; m_ctr = 0;
    e_valid = 0; e_taken = 0; e_ill = 0;
  endtask

  // Architectural model of one clock: decide from the ISA rules what the unit must do.
  task automatic model_step(input logic v, input logic [31:0] ins, input logic [31:0] crv,
                            input logic m, input logic we, input logic [1:0] sel,
                            input logic [63:0] wd, input logic rd, input logic [63:0] ra,
                            input logic rdy);
    int unsigned opc, bov, biv, xov;
    logic bo0, bo1, bo2, bo3, aa, lk, is_br, tk, ill, dec, ctr_nz, ctr_ok, cond_ok;
    logic lr_br, ctr_br, acc;
    logic [63:0] off, tgt, ctrm, seq;
    acc = v && (!e_valid || rdy) && !rd;
    lr_br = 0; ctr_br = 0;
    if (rd) begin
      m_cia = ra; e_nia = ra; e_valid = 1; e_taken = 1; e_ill = 0;
    end else if (acc) begin
      opc = ins >> 26; bov = (ins >> 21) & 31; biv = (ins >> 16) & 31; xov = (ins >> 1) & 1023;
      bo0 = bov[4]; bo1 = bov[3]; bo2 = bov[2]; bo3 = bov[1];
      aa = ins[1]; lk = ins[0];
      seq = m_cia + 4;
      ctrm = m_ctr - 1;
      ctr_nz = m ? ((ctrm % 64'h1_0000_0000) != 0) : (ctrm != 0);
      ctr_ok = bo2 || (ctr_nz != bo3);
      cond_ok = bo0 || (((crv >> (31 - biv)) & 1) == bo1);
      is_br = 0; tk = 0; ill = 0; dec = 0; tgt = seq;
      if (opc == 18) begin
        off = ins & 32'h03FF_FFFC;
        if (ins[25]) off = off - 64'h400_0000;
        is_br = 1; tk = 1; tgt = off + (aa ? 64'd0 : m_cia);
      end else if (opc == 16) begin
        off = ins & 32'h0000_FFFC;
        if (ins[15]) off = off - 64'h1_0000;
        is_br = 1; dec = !bo2; tk = ctr_ok && cond_ok; tgt = off + (aa ? 64'd0 : m_cia);
      end else if (opc == 19) begin
        if (xov == 16) begin
          is_br = 1; dec = !bo2; tk = ctr_ok && cond_ok; tgt = (m_lr >> 2) << 2;
        end else if (xov == 528 && bo2) begin
          is_br = 1; tk = cond_ok; tgt = (m_ctr >> 2) << 2;
        end else begin
          ill = 1;
        end
      end
      e_nia = msk(m, tk ? tgt : seq);
      m_cia = e_nia; e_valid = 1; e_taken = tk; e_ill = ill;
      if (is_br && lk) begin m_lr = msk(m, seq); lr_br = 1; end
      if (dec) begin m_ctr = ctrm; ctr_br = 1; end
    end else if (rdy) begin
      e_valid = 0;
    end
    if (we && sel == 0 && !lr_br) m_lr = wd;
    if (we && sel == 1 && !ctr_br) m_ctr = wd;
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] crv,
                      input logic m, input logic we, input logic [1:0] sel,
                      input logic [63:0] wd, input logic rd, input logic [63:0] ra,
                      input logic rdy);
    @(negedge clk);
    in_valid = v; instr = ins; cr = crv; mode = m; spr_we = we; spr_sel = sel;
    spr_wdata = wd; redirect = rd; redirect_addr = ra; out_ready = rdy;
    #1;
    e_ready = (!e_valid || rdy) && !rd;
    check("ready", {63'd0, o_ready}, {63'd0, e_ready});
    model_step(v, ins, crv, m, we, sel, wd, rd, ra, rdy);
    @(posedge clk);
    #1;
    check("valid", {63'd0, o_valid}, {63'd0, e_valid});
    check("nia", o_nia, e_nia);
    check("taken", {63'd0, o_taken}, {63'd0, e_taken});
    check("illegal", {63'd0, o_illegal}, {63'd0, e_ill});
    check("lr", o_lr, m_lr);
    check("ctr", o_ctr, m_ctr);
    check("tar", o_tar, 64'd0);
    in_valid = 0; spr_we = 0; redirect = 0;
  endtask

  task automatic go(input logic [31:0] ins, input logic [31:0] crv, input logic m);
    step(1'b1, ins, crv, m, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, 1'b1);
  endtask

  task automatic redir(input logic [63:0] a);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 64'd0, 1'b1, a, 1'b1);
  endtask

  task automatic sprw(input logic [1:0] sel, input logic [63:0] d);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, sel, d, 1'b0, 64'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] ins;
    logic [63:0] held;
    int unsigned cls, opc;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_nia", o_nia, 64'h100);
    check("rst_lr", o_lr, 64'd0);
    check("rst_ctr", o_ctr, 64'd0);
    rst = 1'b1;

    // b +0x20 from 0x100
    go(32'h4800_0020, 32'd0, 1'b0);
    check("b_nia", o_nia, 64'h120);
    check("b_taken", {63'd0, o_taken}, 64'd1);

    // bdnz -8 twice with CTR = 2
    redir(64'h200);
    sprw(2'd1, 64'd2);
    go(32'h4200_FFF8, 32'd0, 1'b0);
    check("bdnz1_nia", o_nia, 64'h1F8);
    check("bdnz1_ctr", o_ctr, 64'd1);
    go(32'h4200_FFF8, 32'd0, 1'b0);
    check("bdnz2_nia", o_nia, 64'h1FC);
    check("bdnz2_ctr", o_ctr, 64'd0);
    check("bdnz2_taken", {63'd0, o_taken}, 64'd0);

    // beq cr0 +0x10
    redir(64'h300);
    go(32'h4182_0010, 32'h2000_0000, 1'b0);
    check("beq_t_nia", o_nia, 64'h310);
    redir(64'h300);
    go(32'h4182_0010, 32'h0000_0000, 1'b0);
    check("beq_nt_nia", o_nia, 64'h304);

    // blrl with coincident LR write: branch wins
    sprw(2'd0, 64'h1234);
    redir(64'h400);
    step(1'b1, 32'h4E80_0021, 32'd0, 1'b0, 1'b1, 2'd0, 64'hDEAD, 1'b0, 64'd0, 1'b1);
    check("blrl_nia", o_nia, 64'h1234);
    check("blrl_lr", o_lr, 64'h404);

    // 32-bit wrap, then stall fetch for three cycles
    redir(64'hFFFF_FFFC);
    go(32'h6000_0000, 32'd0, 1'b1);
    check("wrap_nia", o_nia, 64'd0);
    held = o_nia;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h4800_0040, 32'd0, 1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, 1'b0);
      check("hold_nia", o_nia, held);
      check("hold_ready", {63'd0, o_ready}, 64'd0);
    end
    go(32'h4800_0040, 32'd0, 1'b1);
    check("release_nia", o_nia, 64'h40);

    // Illegal forms
    sprw(2'd1, 64'h55);
    go(32'h4C00_0420, 32'd0, 1'b0);
    check("bcctr_ill", {63'd0, o_illegal}, 64'd1);
    check("bcctr_ctr", o_ctr, 64'h55);
    go(32'h4E80_0460, 32'd0, 1'b0);
    check("bctar_ill", {63'd0, o_illegal}, 64'd1);

    // Redirect beats a coincident bl
    held = o_lr;
    step(1'b1, 32'h4800_0021, 32'd0, 1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'h700, 1'b1);
    check("redir_nia", o_nia, 64'h700);
    check("redir_lr", o_lr, held);

    // Asynchronous reset mid-operation
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid", {63'd0, o_valid}, 64'd0);
    check("arst_nia", o_nia, 64'h100);
    check("arst_ctr", o_ctr, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(0, 5);
      ins = $urandom;
      case (cls)
        0: ins[31:26] = 6'd18;
        1: ins[31:26] = 6'd16;
        2: begin ins[31:26] = 6'd19; ins[10:1] = 10'd16; end
        3: begin ins[31:26] = 6'd19; ins[10:1] = 10'd528; end
        4: begin
          ins[31:26] = 6'd19;
          if ($urandom_range(0, 1) == 1) ins[10:1] = 10'd560;
        end
        default: begin
          opc = $urandom_range(0, 63);
          if (opc >= 16 && opc <= 19) opc = 31;
          ins[31:26] = 6'(opc);
        end
      endcase
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
           $urandom_range(0, 15) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
